// File: rtl/alu_sub_pkg.sv
// Shared types and sizing helpers for the multi-cycle carry-skip subtractor.
package alu_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SUB_DEF_WIDTH = 32;
  localparam int SUB_DEF_BLOCK = 4;

  function automatic int slice_count(input int w, input int b);
    return w / b;
  endfunction

endpackage

// File: rtl/skip_slice.sv
// One BLOCK-bit carry-skip slice of a + ~b: ripple sum, with the block carry
// bypassed straight from cin whenever every bit propagates.
module skip_slice #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a_s,
  input  logic [BLOCK-1:0] nb_s,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout,
  output logic             skip
);

  logic [BLOCK-1:0] p;
  logic             rc;

  always_comb begin
    p  = a_s ^ nb_s;
    rc = cin;
    s  = '0;
    for (int i = 0; i < BLOCK; i++) begin
      s[i] = p[i] ^ rc;
      rc   = (a_s[i] & nb_s[i]) | (p[i] & rc);
    end
    skip = &p;
    cout = skip ? cin : rc;
  end

endmodule

// File: rtl/skip_block_subtractor.sv
// Multi-cycle a - b, one carry-skip slice per cycle, LSB slice first.
// Define SUB_SKIP_STATS_EN to add the skip_cnt port and skipped-block counter.
module skip_block_subtractor
  import alu_sub_pkg::*;
#(
  parameter int WIDTH = SUB_DEF_WIDTH,
  parameter int BLOCK = SUB_DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`ifdef SUB_SKIP_STATS_EN
  ,
  output logic [$clog2(WIDTH/BLOCK):0] skip_cnt
`endif
);

  localparam int N    = slice_count(WIDTH, BLOCK);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % BLOCK != 0) begin : g_bad_cfg
    $error("skip_block_subtractor: WIDTH must be a multiple of BLOCK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, nb_q, nb_d;
  logic [WIDTH-1:0] work_q, work_d, res_q, res_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d, zero_q, zero_d;
  logic             neg_q, neg_d, ovf_q, ovf_d;

  logic [BLOCK-1:0] a_sl, nb_sl, s_sl;
  logic             cout_sl, skip_sl, last_sl;

  skip_slice #(.BLOCK(BLOCK)) u_slice (
    .a_s  (a_sl),
    .nb_s (nb_sl),
    .cin  (carry_q),
    .s    (s_sl),
    .cout (cout_sl),
    .skip (skip_sl)
  );

  // Constant part-selects keep the slice mux free of variable-width arithmetic.
  always_comb begin
    a_sl  = '0;
    nb_sl = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_sl  = a_q[i*BLOCK +: BLOCK];
        nb_sl = nb_q[i*BLOCK +: BLOCK];
      end
    end
  end

  assign last_sl = (idx_q == IDXW'(N - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    nb_d     = nb_q;
    work_d   = work_q;
    res_d    = res_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          nb_d    = ~b;
          carry_d = 1'b1;
          idx_d   = '0;
          work_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDXW'(i)) work_d[i*BLOCK +: BLOCK] = s_sl;
        end
        carry_d = cout_sl;
        idx_d   = idx_q + 1'b1;
        if (last_sl) begin
          // Flags come from the fully assembled difference, final slice included.
          res_d    = work_d;
          borrow_d = ~cout_sl;
          zero_d   = (work_d == '0);
          neg_d    = work_d[WIDTH-1];
          ovf_d    = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
          idx_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      nb_q     <= '0;
      work_q   <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      work_q   <= work_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef SUB_SKIP_STATS_EN
  logic [$clog2(N):0] skip_q, skip_d;

  always_comb begin
    skip_d = skip_q;
    if (state_q == IDLE && in_valid) skip_d = '0;
    else if (state_q == RUN && skip_sl) skip_d = skip_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) skip_q <= '0;
    else     skip_q <= skip_d;
  end

  assign skip_cnt = skip_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = res_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_skip_block_subtractor.sv
// Randomized bench for skip_block_subtractor against an arithmetic reference model.
module tb_skip_block_subtractor;

  localparam int W = 32;
  localparam int B = 4;
  localparam int N = W / B;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  diff;
  logic          borrow, zero, neg, ovf;
`ifdef SUB_SKIP_STATS_EN
  logic [$clog2(N):0] skip_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  skip_block_subtractor #(.WIDTH(W), .BLOCK(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
`ifdef SUB_SKIP_STATS_EN
    ,
    .skip_cnt  (skip_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; a block skips when its a and b nibbles match.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int hold);
    logic [W-1:0] ed;
    logic         eb, ez, en, eo;
    longint       sd;
    int           esk, cyc;
    ed  = ta - tb_v;
    eb  = (ta < tb_v);
    ez  = (ed == 0);
    en  = ($signed(ed) < 0);
    sd  = longint'($signed(ta)) - longint'($signed(tb_v));
    eo  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    esk = 0;
    for (int i = 0; i < N; i++)
      if (((ta >> (i*B)) & 4'hF) == ((tb_v >> (i*B)) & 4'hF)) esk++;

    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; a = $urandom; b = $urandom;
    cyc = 0;
    while (1) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (out_valid || cyc > 40) break;
    end
    chk("latency", cyc, N);
    chk("diff", diff, ed);
    chk("borrow", borrow, eb);
    chk("zero", zero, ez);
    chk("neg", neg, en);
    chk("ovf", ovf, eo);
`ifdef SUB_SKIP_STATS_EN
    chk("skip_cnt", skip_cnt, esk);
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = $urandom_range(0, 1);
      a = $urandom; b = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_diff", diff, ed);
      chk("hold_borrow", borrow, eb);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("idle_keeps_diff", diff, ed);
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_flags", {borrow, zero, neg, ovf}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    run_op(32'd5, 32'd3, 0);
    run_op(32'd3, 32'd5, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 0);
    run_op(32'h1234_5678, 32'h1234_5678, 0);
    run_op(32'hDEAD_BEEF, 32'd0, 3);

    // Abort mid-RUN: no result may ever appear, then a clean operation follows.
    @(negedge clk);
    a = 32'd7; b = 32'd2; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_diff", diff, 0);
    chk("abort_flags", {borrow, zero, neg, ovf}, 0);
`ifdef SUB_SKIP_STATS_EN
    chk("abort_skip_cnt", skip_cnt, 0);
`endif
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    run_op(32'd9, 32'd4, 0);

    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      unique case (k % 4)
        0: rb = $urandom;
        1: rb = ra;
        2: rb = 32'd0;
        default: rb = ra ^ (32'hF << (4 * $urandom_range(0, N - 1)));
      endcase
      run_op(ra, rb, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
